mem_io_responder: RTL and testbench

Byte-wide responder on the far end of the memory controller's RAM bus. It accepts one byte access per cycle (address, write data, read/write select) and returns read data with one-cycle latency. Backing store is either on-chip byte RAM or a small memory-mapped I/O window. The I/O window carries a transmit FIFO toward the host, a receive FIFO from the host, a status register and a halt register. The block sits between the CPU-side memory controller and the top-level RAM/UART pins, and drives the controller's `io_buffer_full` back-pressure input.

---
 rtl/mem_io_responder.sv | 123 ++++++++++++
 tb/tb_mem_io_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide RAM/IO responder for the memory controller bus: on-chip byte RAM plus a
// small I/O window with host-bound TX FIFO, host-to-CPU RX FIFO, STATUS and HALT.
module mem_io_responder #(
   parameter int unsigned ADDR_WIDTH  = 17,
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned RX_DEPTH    = 16,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_addr,
   input  logic [7:0]  mem_write,
   input  logic        r_nw_in,
   output logic [7:0]  mem_read,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        halted
);

   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned TX_CW = TX_AW + 1;
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);
   localparam int unsigned RX_CW = RX_AW + 1;
   localparam logic [2:0]  OFF_UART = 3'd0;
   localparam logic [2:0]  OFF_CTRL = 3'd4;

   logic [7:0]            ram    [2**ADDR_WIDTH];
   logic [7:0]            tx_mem [TX_DEPTH];
   logic [7:0]            rx_mem [RX_DEPTH];

   logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
   logic [TX_CW-1:0]      tx_count;
   logic [RX_AW-1:0]      rx_wr_ptr, rx_rd_ptr;
   logic [RX_CW-1:0]      rx_count;
   logic                  tx_overflow;

   logic                  io_sel;
   logic [2:0]            io_off;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  tx_empty, tx_full, rx_empty, rx_full;
   logic                  tx_push_req, tx_push, tx_pop;
   logic                  rx_pop_req, rx_pop, rx_push;
   logic                  halt_wr;
   logic [TX_CW-1:0]      tx_free_c;
   logic [7:0]            io_rd_c;
   logic                  unused_addr;

   assign io_sel   = (mem_addr[17:16] == 2'b11);
   assign io_off   = mem_addr[2:0];
   assign ram_addr = mem_addr[ADDR_WIDTH-1:0];
   assign unused_addr = ^mem_addr;

   assign tx_empty = (tx_count == '0);
   assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));

   assign tx_valid = !tx_empty;
   assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
   assign rx_ready = !rx_full && !rst_in;

   // A push into a full TX FIFO still lands when the head leaves in the same cycle.
   assign tx_pop      = tx_valid && tx_ready;
   assign tx_push_req = rdy_in && io_sel && !r_nw_in && (io_off == OFF_UART);
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign rx_push     = rx_valid && rx_ready;
   assign rx_pop_req  = rdy_in && io_sel && r_nw_in && (io_off == OFF_UART);
   assign rx_pop      = rx_pop_req && !rx_empty;
   assign halt_wr     = rdy_in && io_sel && !r_nw_in && (io_off == OFF_CTRL);

   assign tx_free_c      = TX_CW'(TX_DEPTH) - tx_count;
   assign io_buffer_full = (tx_free_c <= TX_CW'(FULL_MARGIN));

   // I/O window read mux.
   always_comb begin
      io_rd_c = 8'h00;
      case (io_off)
         OFF_UART: io_rd_c = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
         OFF_CTRL: io_rd_c = {5'b0, tx_overflow, !rx_empty, tx_full};
         default:  io_rd_c = 8'h00;
      endcase
   end

   // Storage arrays carry no reset; pointers alone define FIFO contents.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !r_nw_in && !io_sel) ram[ram_addr] <= mem_write;
      if (tx_push) tx_mem[tx_wr_ptr] <= mem_write;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_read    <= 8'h00;
         halted      <= 1'b0;
         tx_overflow <= 1'b0;
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_count    <= '0;
         rx_wr_ptr   <= '0;
         rx_rd_ptr   <= '0;
         rx_count    <= '0;
      end else begin
         if (rdy_in && r_nw_in) mem_read <= io_sel ? io_rd_c : ram[ram_addr];
         if (halt_wr) halted <= 1'b1;
         if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;

         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
         tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);

         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM vector table plus hand sequences for
// RX/TX FIFOs, back-pressure, rdy_in freeze, HALT and mid-stream reset.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, r_nw_in;
   logic [31:0] mem_addr;
   logic [7:0]  mem_write, mem_read;
   logic        io_buffer_full;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, halted;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  wd;
      logic        rnw;
      logic        chk;
      logic [7:0]  exp;
   } vec_t;

   vec_t vt[13];

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_addr(mem_addr), .mem_write(mem_write), .r_nw_in(r_nw_in),
      .mem_read(mem_read), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .halted(halted)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic rnw);
      mem_addr  = a;
      mem_write = d;
      r_nw_in   = rnw;
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      vt[0]  = '{32'h0000_0100, 8'h11, 1'b0, 1'b0, 8'h00};
      vt[1]  = '{32'h0000_0101, 8'h22, 1'b0, 1'b0, 8'h00};
      vt[2]  = '{32'h0000_0102, 8'h33, 1'b0, 1'b0, 8'h00};
      vt[3]  = '{32'h0000_0103, 8'h44, 1'b0, 1'b0, 8'h00};
      vt[4]  = '{32'h0000_0100, 8'h00, 1'b1, 1'b1, 8'h11};
      vt[5]  = '{32'h0000_0101, 8'h00, 1'b1, 1'b1, 8'h22};
      vt[6]  = '{32'h0000_0102, 8'h00, 1'b1, 1'b1, 8'h33};
      vt[7]  = '{32'h0000_0103, 8'h00, 1'b1, 1'b1, 8'h44};
      vt[8]  = '{32'h0000_0105, 8'h77, 1'b0, 1'b0, 8'h00};
      vt[9]  = '{32'h0000_0105, 8'h00, 1'b1, 1'b1, 8'h77};
      vt[10] = '{32'h0002_0103, 8'h00, 1'b1, 1'b1, 8'h44};
      vt[11] = '{32'hFFFC_0101, 8'h00, 1'b1, 1'b1, 8'h22};
      vt[12] = '{32'h0003_0002, 8'h00, 1'b1, 1'b1, 8'h00};

      rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0;
      rx_valid = 1'b0; rx_data = 8'h00;
      bus(32'h0, 8'h00, 1'b1);
      step(); step();
      chk8("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
      chk8("rst_mem_read", mem_read, 8'h00);
      chk8("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      chk8("rst_tx_data", tx_data, 8'h00);
      chk8("rst_buf_full", {7'b0, io_buffer_full}, 8'h00);
      chk8("rst_halted", {7'b0, halted}, 8'h00);
      rst_in = 1'b0;
      #1;
      chk8("rx_ready_after_rst", {7'b0, rx_ready}, 8'h01);

      // RAM vectors
      for (int i = 0; i < 13; i++) begin
         bus(vt[i].addr, vt[i].wd, vt[i].rnw);
         step();
         if (vt[i].chk) chk8($sformatf("ram_vec%0d", i), mem_read, vt[i].exp);
      end

      // RX basic
      bus(32'h0, 8'h00, 1'b1);
      rx_valid = 1'b1; rx_data = 8'hA5; step();
      rx_data = 8'h5A; step();
      rx_valid = 1'b0;
      bus(32'h0003_0004, 8'h00, 1'b1); step();
      chk8("rx_status_2", mem_read, 8'h02);
      bus(32'h0003_0000, 8'h00, 1'b1);
      step(); chk8("rx_pop_a5", mem_read, 8'hA5);
      step(); chk8("rx_pop_5a", mem_read, 8'h5A);
      step(); chk8("rx_pop_empty", mem_read, 8'h00);
      bus(32'h0003_0004, 8'h00, 1'b1); step();
      chk8("rx_status_0", mem_read, 8'h00);

      // RX pop from empty with simultaneous push
      bus(32'h0003_0000, 8'h00, 1'b1);
      rx_valid = 1'b1; rx_data = 8'h3C; step();
      rx_valid = 1'b0;
      chk8("rx_simul_empty", mem_read, 8'h00);
      step(); chk8("rx_simul_queued", mem_read, 8'h3C);

      // RX fill to full
      bus(32'h0, 8'h00, 1'b1);
      rx_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx_data = 8'(8'h80 + i);
         step();
      end
      chk8("rx_full_ready", {7'b0, rx_ready}, 8'h00);
      rx_data = 8'hFF; step();
      rx_valid = 1'b0;
      bus(32'h0003_0000, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) begin
         step();
         chk8($sformatf("rx_drain%0d", i), mem_read, 8'(8'h80 + i));
      end
      step(); chk8("rx_drain_empty", mem_read, 8'h00);

      // TX fill and back-pressure
      tx_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         bus(32'h0003_0000, 8'(i + 1), 1'b0);
         step();
         if (i == 0) begin
            chk8("tx_valid_1st", {7'b0, tx_valid}, 8'h01);
            chk8("tx_data_1st", tx_data, 8'h01);
         end
         chk8($sformatf("tx_full_w%0d", i + 1), {7'b0, io_buffer_full}, (i == 13) ? 8'h01 : 8'h00);
      end
      bus(32'h0003_0000, 8'd15, 1'b0); step();
      bus(32'h0003_0000, 8'd16, 1'b0); step();
      bus(32'h0003_0000, 8'h77, 1'b0); step();
      bus(32'h0003_0004, 8'h00, 1'b1); step();
      chk8("tx_status_ovf", mem_read, 8'h05);

      // push and pop while full
      tx_ready = 1'b1;
      bus(32'h0003_0000, 8'h55, 1'b0); step();
      tx_ready = 1'b0;
      bus(32'h0003_0004, 8'h00, 1'b1); step();
      chk8("tx_status_full_pp", mem_read, 8'h05);
      chk8("tx_head_after_pp", tx_data, 8'h02);

      // drain with bus frozen
      rdy_in = 1'b0;
      tx_ready = 1'b1;
      bus(32'h0000_0100, 8'hEE, 1'b0);
      for (int k = 0; k < 16; k++) begin
         if (k == 8) bus(32'h0003_0000, 8'h99, 1'b0);
         chk8($sformatf("drain_valid%0d", k), {7'b0, tx_valid}, 8'h01);
         chk8($sformatf("drain_data%0d", k), tx_data, (k < 15) ? 8'(k + 2) : 8'h55);
         chk8($sformatf("drain_full%0d", k), {7'b0, io_buffer_full}, (k < 3) ? 8'h01 : 8'h00);
         step();
      end
      chk8("drain_done_valid", {7'b0, tx_valid}, 8'h00);
      chk8("frozen_mem_read", mem_read, 8'h05);
      rdy_in = 1'b1;
      tx_ready = 1'b0;
      bus(32'h0000_0100, 8'h00, 1'b1); step();
      chk8("frozen_ram_write", mem_read, 8'h11);
      bus(32'h0003_0004, 8'h00, 1'b1); step();
      chk8("status_ovf_sticky", mem_read, 8'h04);
      chk8("frozen_tx_write", {7'b0, tx_valid}, 8'h00);

      // HALT
      chk8("halted_pre", {7'b0, halted}, 8'h00);
      bus(32'h0003_0004, 8'h00, 1'b0); step();
      chk8("halted_set", {7'b0, halted}, 8'h01);
      bus(32'h0000_0104, 8'h66, 1'b0); step();
      bus(32'h0000_0104, 8'h00, 1'b1); step();
      chk8("halted_ram_ok", mem_read, 8'h66);
      chk8("halted_sticky", {7'b0, halted}, 8'h01);

      // reset mid TX drain
      bus(32'h0003_0000, 8'hA1, 1'b0); step();
      bus(32'h0003_0000, 8'hA2, 1'b0); step();
      bus(32'h0003_0000, 8'hA3, 1'b0); step();
      bus(32'h0, 8'h00, 1'b1);
      tx_ready = 1'b1; step();
      chk8("mid_drain_head", tx_data, 8'hA2);
      rst_in = 1'b1;
      bus(32'h0000_0100, 8'h00, 1'b1); step();
      chk8("mid_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      chk8("mid_rst_tx_data", tx_data, 8'h00);
      chk8("mid_rst_halted", {7'b0, halted}, 8'h00);
      chk8("mid_rst_mem_read", mem_read, 8'h00);
      chk8("mid_rst_full", {7'b0, io_buffer_full}, 8'h00);
      rst_in = 1'b0;
      tx_ready = 1'b0;
      step();
      chk8("post_rst_ram", mem_read, 8'h11);
      chk8("post_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      bus(32'h0003_0004, 8'h00, 1'b1); step();
      chk8("post_rst_status", mem_read, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
